// File: rtl/scaler_frame_ctrl.sv
// scaler_frame_ctrl
//   Configuration and frame sequencer for the bilinear scaler. A size request is
//   checked, its scale factors are derived by a shared serial restoring divider
//   (X then Y), and the whole set is loaded into the scaler in one step at a frame
//   boundary while the scaler datapath is held in reset. Scaler output pixels are
//   counted against the active dest size to produce frame_done and vsync.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   cfg_wr_i, cfg_*_i             size request strobe and requested dimensions
//   cfg_busy_o, cfg_err_o         request in progress / last request rejected
//   out_tvalid_i                  scaler output pixel valid
//   src_*_o, dest_*_o             active configuration presented to the scaler
//   scale_factorx_o/_y_o          active fixed-point scale factors (saturated)
//   scaler_rst_o                  reset to the scaler datapath
//   frame_done_o, tvsync_o        end-of-frame pulse and vertical sync

module scaler_frame_ctrl #(
    parameter int unsigned INT_WIDTH  = 8,
    parameter int unsigned FIX_WIDTH  = 12,
    parameter int unsigned RST_CYCLES = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           cfg_wr_i,
    input  logic [15:0]                    cfg_src_width_i,
    input  logic [15:0]                    cfg_src_height_i,
    input  logic [15:0]                    cfg_dest_width_i,
    input  logic [15:0]                    cfg_dest_height_i,
    output logic                           cfg_busy_o,
    output logic                           cfg_err_o,
    input  logic                           out_tvalid_i,
    output logic [15:0]                    src_width_o,
    output logic [15:0]                    src_height_o,
    output logic [15:0]                    dest_width_o,
    output logic [15:0]                    dest_height_o,
    output logic [INT_WIDTH+FIX_WIDTH-1:0] scale_factorx_o,
    output logic [INT_WIDTH+FIX_WIDTH-1:0] scale_factory_o,
    output logic                           scaler_rst_o,
    output logic                           frame_done_o,
    output logic                           tvsync_o
);

    localparam int unsigned N  = INT_WIDTH + FIX_WIDTH;  // quotient bits
    localparam int unsigned EW = N + 16;                 // extended dividend width
    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned RW = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DIV_X, S_DIV_Y, S_WAIT_EOF, S_LOAD, S_RUN
    } state_t;

    state_t r_state, w_state_nxt;

    // pending request
    logic [15:0]   r_pend_sw, r_pend_sh, r_pend_dw, r_pend_dh;
    logic [N-1:0]  r_fx_pend, r_fy_pend;
    logic          r_err;
    logic          r_cfg_valid;
    logic [RW-1:0] r_rst_cnt;

    // divider
    logic [15:0]   r_div_rem, r_div_den;
    logic [N-1:0]  r_div_q;
    logic          r_div_sat;
    logic [CW-1:0] r_div_cnt;

    // pixel counting
    logic [15:0]   r_x_cnt, r_y_cnt;
    logic          r_frame_done, r_vsync;

    logic          w_accept, w_zero, w_start;
    logic [15:0]   w_div_src, w_div_den;
    logic [EW-1:0] w_ext;
    logic [16:0]   w_trial, w_diff;
    logic          w_ge;
    logic [15:0]   w_rem_nxt;
    logic [N-1:0]  w_q_nxt, w_div_res, w_fy_load;
    logic          w_div_last, w_load_entry;
    logic          w_pix, w_x_wrap, w_last_pix, w_frame_busy;

    assign w_accept = cfg_wr_i && (r_state == S_IDLE || r_state == S_RUN);
    assign w_zero   = (cfg_src_width_i == '0) || (cfg_src_height_i == '0) ||
                      (cfg_dest_width_i == '0) || (cfg_dest_height_i == '0);
    assign w_start  = w_accept && !w_zero;

    // The X division is seeded straight from the request inputs on accept; the Y
    // division is seeded from the pending registers on the last DIV_X cycle.
    assign w_div_src = (r_state == S_DIV_X) ? r_pend_sh : cfg_src_width_i;
    assign w_div_den = (r_state == S_DIV_X) ? r_pend_dh : cfg_dest_width_i;
    assign w_ext     = EW'(w_div_src) << FIX_WIDTH;

    // One restoring step. The remainder is seeded with the dividend bits above the
    // quotient field, which are below the divisor whenever no saturation occurs,
    // so only N steps are needed and the remainder always fits in 16 bits.
    assign w_trial    = {r_div_rem, r_div_q[N-1]};
    assign w_ge       = w_trial >= {1'b0, r_div_den};
    assign w_diff     = w_trial - {1'b0, r_div_den};
    assign w_rem_nxt  = w_ge ? w_diff[15:0] : w_trial[15:0];
    assign w_q_nxt    = {r_div_q[N-2:0], w_ge};
    assign w_div_res  = r_div_sat ? '1 : w_q_nxt;
    assign w_div_last = (r_div_cnt == CW'(N - 1));
    assign w_fy_load  = (r_state == S_DIV_Y) ? w_div_res : r_fy_pend;

    // Pixels are counted whenever an active config drives the scaler, including
    // while a new request is being divided or waits for end of frame.
    assign w_pix        = out_tvalid_i && r_cfg_valid && (r_state != S_LOAD);
    assign w_x_wrap     = (r_x_cnt == dest_width_o - 16'd1);
    assign w_last_pix   = w_pix && w_x_wrap && (r_y_cnt == dest_height_o - 16'd1);
    // A frame completing in the very cycle the division ends is treated as ended.
    assign w_frame_busy = ((r_x_cnt != '0) || (r_y_cnt != '0)) && !w_last_pix;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_RUN: if (w_start) w_state_nxt = S_DIV_X;
            S_DIV_X:       if (w_div_last) w_state_nxt = S_DIV_Y;
            S_DIV_Y:       if (w_div_last) w_state_nxt = w_frame_busy ? S_WAIT_EOF : S_LOAD;
            S_WAIT_EOF:    if (w_last_pix) w_state_nxt = S_LOAD;
            S_LOAD:        if (r_rst_cnt == RW'(RST_CYCLES - 1)) w_state_nxt = S_RUN;
            default:       w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_busy_o   = 1'b0;
        scaler_rst_o = !r_cfg_valid;
        case (r_state)
            S_DIV_X, S_DIV_Y, S_WAIT_EOF: cfg_busy_o = 1'b1;
            S_LOAD: begin
                cfg_busy_o   = 1'b1;
                scaler_rst_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_load_entry = (w_state_nxt == S_LOAD) && (r_state != S_LOAD);
    assign cfg_err_o    = r_err;
    assign frame_done_o = r_frame_done;
    assign tvsync_o     = r_vsync;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_rst_cnt   <= '0;
            r_cfg_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rst_cnt <= (r_state == S_LOAD) ? r_rst_cnt + 1'b1 : '0;
            if (r_state == S_LOAD && w_state_nxt == S_RUN) r_cfg_valid <= 1'b1;
            if (w_accept) r_err <= w_zero;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pend_sw <= '0;
            r_pend_sh <= '0;
            r_pend_dw <= '0;
            r_pend_dh <= '0;
            r_fx_pend <= '0;
            r_fy_pend <= '0;
            r_div_rem <= '0;
            r_div_den <= '0;
            r_div_q   <= '0;
            r_div_sat <= 1'b0;
            r_div_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_pend_sw <= cfg_src_width_i;
                r_pend_sh <= cfg_src_height_i;
                r_pend_dw <= cfg_dest_width_i;
                r_pend_dh <= cfg_dest_height_i;
            end
            if (w_start || (r_state == S_DIV_X && w_div_last)) begin
                r_div_rem <= w_ext[EW-1:N];
                r_div_q   <= w_ext[N-1:0];
                r_div_den <= w_div_den;
                r_div_sat <= w_ext[EW-1:N] >= w_div_den;
                r_div_cnt <= '0;
            end else if (r_state == S_DIV_X || r_state == S_DIV_Y) begin
                r_div_rem <= w_rem_nxt;
                r_div_q   <= w_q_nxt;
                r_div_cnt <= r_div_cnt + 1'b1;
            end
            if (r_state == S_DIV_X && w_div_last) r_fx_pend <= w_div_res;
            if (r_state == S_DIV_Y && w_div_last) r_fy_pend <= w_div_res;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            src_width_o     <= '0;
            src_height_o    <= '0;
            dest_width_o    <= '0;
            dest_height_o   <= '0;
            scale_factorx_o <= '0;
            scale_factory_o <= '0;
        end else if (w_load_entry) begin
            src_width_o     <= r_pend_sw;
            src_height_o    <= r_pend_sh;
            dest_width_o    <= r_pend_dw;
            dest_height_o   <= r_pend_dh;
            scale_factorx_o <= r_fx_pend;
            scale_factory_o <= w_fy_load;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_x_cnt      <= '0;
            r_y_cnt      <= '0;
            r_frame_done <= 1'b0;
            r_vsync      <= 1'b0;
        end else begin
            if (w_load_entry || r_state == S_LOAD) begin
                r_x_cnt <= '0;
                r_y_cnt <= '0;
            end else if (w_pix) begin
                if (w_last_pix) begin
                    r_x_cnt <= '0;
                    r_y_cnt <= '0;
                end else if (w_x_wrap) begin
                    r_x_cnt <= '0;
                    r_y_cnt <= r_y_cnt + 16'd1;
                end else begin
                    r_x_cnt <= r_x_cnt + 16'd1;
                end
            end
            r_frame_done <= w_last_pix;
            if (w_last_pix)  r_vsync <= 1'b1;
            else if (w_pix)  r_vsync <= 1'b0;
        end
    end

endmodule
